// File: rtl/acc_rd_pkg.sv
// Shared types and helpers for the acc_user read channel.
package acc_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } rd_state_e;

   // Address stride of one line: the line width in bytes.
   function automatic int unsigned line_bytes_of(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/acc_read_fifo.sv
// Line buffer with registered read port; pop on empty and push on full are ignored.
module acc_read_fifo #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_WIDTH-1:0]    push_data,
   input  logic                     pop,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  push_ok, pop_ok;

   // Next-state for pointers, occupancy flags and the read register.
   always_comb begin
      push_ok      = push && !full_q;
      pop_ok       = pop && !empty_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      dout_d       = dout_q;
      dout_valid_d = pop_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         dout_d   = mem_q[rd_ptr_q[IDX_W-1:0]];
      end
      count_d = count_q + PTR_W'(push_ok) - PTR_W'(pop_ok);
      empty_d = (count_d == '0);
      full_d  = (count_d == PTR_W'(DEPTH));
   end

   // Control and read-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   // Storage array; contents need no reset because occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign count      = count_q;
   assign empty      = empty_q;
   assign full       = full_q;

endmodule

// File: rtl/acc_user_read_channel.sv
// One acc_user read lane: fetches num_lines lines from base_addr and serves pops.
module acc_user_read_channel
   import acc_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LINE_BYTES = line_bytes_of(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  num_lines,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   output logic                  acc_user_available_read,
   input  logic                  acc_user_request_read,
   output logic                  acc_user_read_data_valid,
   output logic [DATA_WIDTH-1:0] acc_user_read_data,
   output logic                  acc_user_done_rd_data
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SUM_W = PTR_W + 1;

   rd_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]  total_q, total_d;
   logic [CNT_WIDTH-1:0]  req_cnt_q, req_cnt_d;
   logic [CNT_WIDTH-1:0]  del_cnt_q, del_cnt_d;
   logic [PTR_W-1:0]      outstanding_q, outstanding_d;
   logic                  req_valid_q, req_valid_d;
   logic                  avail_q, avail_d;
   logic                  done_q, done_d;

   logic [PTR_W-1:0]      fifo_count, count_nxt;
   logic                  fifo_empty, fifo_full;
   logic                  push_c, pop_c, accept_c;
   logic [SUM_W-1:0]      credit_used;

   // Line buffer between the memory port and the consumer.
   acc_read_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_c),
      .push_data  (mem_resp_data),
      .pop        (pop_c),
      .dout       (acc_user_read_data),
      .dout_valid (acc_user_read_data_valid),
      .count      (fifo_count),
      .empty      (fifo_empty),
      .full       (fifo_full)
   );

   // FSM, address/credit counters; request valid is registered from next-state values.
   always_comb begin
      push_c   = mem_resp_valid && (outstanding_q != '0) && !fifo_full;
      pop_c    = acc_user_request_read && !fifo_empty;
      accept_c = req_valid_q && mem_req_ready;
      count_nxt = fifo_count + PTR_W'(push_c) - PTR_W'(pop_c);

      state_d       = state_q;
      addr_d        = addr_q;
      total_d       = total_q;
      req_cnt_d     = req_cnt_q;
      del_cnt_d     = del_cnt_q;
      done_d        = 1'b0;
      outstanding_d = outstanding_q + PTR_W'(accept_c) - PTR_W'(push_c);

      if (accept_c) begin
         addr_d    = addr_q + ADDR_WIDTH'(LINE_BYTES);
         req_cnt_d = req_cnt_q + CNT_WIDTH'(1);
      end

      case (state_q)
         ST_RUN: begin
            if (pop_c) del_cnt_d = del_cnt_q + CNT_WIDTH'(1);
            if (del_cnt_d == total_q) state_d = ST_DONE;
         end
         ST_IDLE, ST_DONE: begin
            done_d = (state_q == ST_DONE) && !start;
            if (start) begin
               addr_d        = base_addr;
               total_d       = num_lines;
               req_cnt_d     = '0;
               del_cnt_d     = '0;
               outstanding_d = '0;
               state_d       = (num_lines == '0) ? ST_DONE : ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      credit_used = SUM_W'(outstanding_d) + SUM_W'(count_nxt);
      req_valid_d = (state_d == ST_RUN) && (req_cnt_d < total_d) &&
                    (credit_used < SUM_W'(FIFO_DEPTH));
      avail_d     = (count_nxt != '0);
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         total_q       <= '0;
         req_cnt_q     <= '0;
         del_cnt_q     <= '0;
         outstanding_q <= '0;
         req_valid_q   <= 1'b0;
         avail_q       <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         total_q       <= total_d;
         req_cnt_q     <= req_cnt_d;
         del_cnt_q     <= del_cnt_d;
         outstanding_q <= outstanding_d;
         req_valid_q   <= req_valid_d;
         avail_q       <= avail_d;
         done_q        <= done_d;
      end
   end

   assign mem_req_valid           = req_valid_q;
   assign mem_req_addr            = addr_q;
   assign acc_user_available_read = avail_q;
   assign acc_user_done_rd_data   = done_q;

endmodule

// File: tb/tb_acc_user_read_channel.sv
// Scoreboard bench for acc_user_read_channel with an in-order fixed-latency memory model.
module tb_acc_user_read_channel;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [63:0]  base_addr;
   logic [31:0]  num_lines;
   logic         mem_req_valid;
   logic [63:0]  mem_req_addr;
   logic         mem_req_ready;
   logic         mem_resp_valid;
   logic [511:0] mem_resp_data;
   logic         acc_user_available_read;
   logic         acc_user_request_read;
   logic         acc_user_read_data_valid;
   logic [511:0] acc_user_read_data;
   logic         acc_user_done_rd_data;

   int           chk_cnt = 0;
   int           pass_cnt = 0;
   int           cyc = 0;
   int           lat = 3;
   logic         pop_en = 1'b0;
   logic         pop_force = 1'b0;
   logic         ev_accept = 1'b0;
   logic [63:0]  ev_addr = '0;

   logic [63:0]  exp_addr_q [$];
   logic [511:0] exp_data_q [$];
   logic [63:0]  pend_addr [$];
   int           pend_due [$];

   always #5 clk = ~clk;

   acc_user_read_channel dut (
      .clk                      (clk),
      .rst                      (rst),
      .start                    (start),
      .base_addr                (base_addr),
      .num_lines                (num_lines),
      .mem_req_valid            (mem_req_valid),
      .mem_req_addr             (mem_req_addr),
      .mem_req_ready            (mem_req_ready),
      .mem_resp_valid           (mem_resp_valid),
      .mem_resp_data            (mem_resp_data),
      .acc_user_available_read  (acc_user_available_read),
      .acc_user_request_read    (acc_user_request_read),
      .acc_user_read_data_valid (acc_user_read_data_valid),
      .acc_user_read_data       (acc_user_read_data),
      .acc_user_done_rd_data    (acc_user_done_rd_data)
   );

   function automatic logic [511:0] data_of(input logic [63:0] a);
      logic [511:0] d;
      for (int i = 0; i < 8; i++) d[i*64 +: 64] = a ^ (64'h5A5A_0000_0000_0000 + 64'(i));
      return d;
   endfunction

   // One clock: memory accepts/returns in order after lat cycles, consumer pops when enabled.
   task automatic tick();
      logic        acc;
      logic [63:0] a;
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
      ev_accept = acc;
      ev_addr   = a;
      if (acc) begin
         pend_addr.push_back(a);
         pend_due.push_back(cyc + lat);
      end
      mem_resp_valid = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = data_of(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      acc_user_request_read = pop_force | (pop_en & acc_user_available_read);
   endtask

   // Pulse start and push the expected address/data stream.
   task automatic do_start(input logic [63:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(b + 64'(i) * 64'd64);
         exp_data_q.push_back(data_of(b + 64'(i) * 64'd64));
      end
      base_addr = b;
      num_lines = 32'(n);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); else pass_cnt++;
      chk_cnt++; if (mem_req_addr !== 64'h0) $display("FAIL reset_req_addr: got %0h want 0", mem_req_addr); else pass_cnt++;
      chk_cnt++; if (acc_user_available_read !== 1'b0) $display("FAIL reset_avail: got %b want 0", acc_user_available_read); else pass_cnt++;
      chk_cnt++; if (acc_user_read_data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", acc_user_read_data_valid); else pass_cnt++;
      chk_cnt++; if (acc_user_read_data !== 512'h0) $display("FAIL reset_data: got %0h want 0", acc_user_read_data); else pass_cnt++;
      chk_cnt++; if (acc_user_done_rd_data !== 1'b0) $display("FAIL reset_done: got %b want 0", acc_user_done_rd_data); else pass_cnt++;
   endtask

   task automatic test_basic();
      int seen = 0;
      logic [63:0]  ea;
      logic [511:0] ed;
      pop_en = 1'b1;
      mem_req_ready = 1'b1;
      do_start(64'h1000, 4);
      for (int i = 0; i < 80 && seen < 4; i++) begin
         tick();
         if (ev_accept) begin
            chk_cnt++;
            if (exp_addr_q.size() == 0) $display("FAIL basic_addr: extra request %0h", ev_addr);
            else begin ea = exp_addr_q.pop_front(); if (ev_addr !== ea) $display("FAIL basic_addr: got %0h want %0h", ev_addr, ea); else pass_cnt++; end
         end
         if (acc_user_read_data_valid) begin
            chk_cnt++;
            if (exp_data_q.size() == 0) $display("FAIL basic_data: unexpected line %0h", acc_user_read_data);
            else begin ed = exp_data_q.pop_front(); if (acc_user_read_data !== ed) $display("FAIL basic_data: got %0h want %0h", acc_user_read_data, ed); else pass_cnt++; end
            seen++;
         end
      end
      chk_cnt++; if (seen !== 4) $display("FAIL basic_count: got %0d lines want 4", seen); else pass_cnt++;
      chk_cnt++; if (acc_user_done_rd_data !== 1'b0) $display("FAIL basic_done_early: got %b want 0", acc_user_done_rd_data); else pass_cnt++;
      tick();
      chk_cnt++; if (acc_user_done_rd_data !== 1'b1) $display("FAIL basic_done: got %b want 1", acc_user_done_rd_data); else pass_cnt++;
      chk_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL basic_req_idle: got %b want 0", mem_req_valid); else pass_cnt++;
   endtask

   task automatic test_zero_length();
      logic any_req = 1'b0;
      do_start(64'h2000, 0);
      chk_cnt++; if (acc_user_done_rd_data !== 1'b0) $display("FAIL zero_done_cleared: got %b want 0", acc_user_done_rd_data); else pass_cnt++;
      if (mem_req_valid) any_req = 1'b1;
      tick();
      chk_cnt++; if (acc_user_done_rd_data !== 1'b1) $display("FAIL zero_done: got %b want 1", acc_user_done_rd_data); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         if (mem_req_valid) any_req = 1'b1;
         tick();
      end
      chk_cnt++; if (any_req !== 1'b0) $display("FAIL zero_no_req: got %b want 0", any_req); else pass_cnt++;
   endtask

   task automatic test_credit();
      int n_acc = 0;
      int seen  = 0;
      logic stable = 1'b1;
      logic [63:0]  ea;
      logic [511:0] ed;
      pop_en = 1'b0;
      do_start(64'h4000, 20);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (ev_accept) begin
            n_acc++;
            chk_cnt++;
            ea = exp_addr_q.pop_front();
            if (ev_addr !== ea) $display("FAIL credit_addr: got %0h want %0h", ev_addr, ea); else pass_cnt++;
         end
      end
      chk_cnt++; if (n_acc !== 8) $display("FAIL credit_accepts: got %0d want 8", n_acc); else pass_cnt++;
      chk_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL credit_req_blocked: got %b want 0", mem_req_valid); else pass_cnt++;
      chk_cnt++; if (mem_req_addr !== 64'h4200) $display("FAIL credit_addr_hold: got %0h want 4200", mem_req_addr); else pass_cnt++;
      chk_cnt++; if (acc_user_available_read !== 1'b1) $display("FAIL credit_avail: got %b want 1", acc_user_available_read); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (mem_req_addr !== 64'h4200 || mem_req_valid !== 1'b0) stable = 1'b0;
      end
      chk_cnt++; if (stable !== 1'b1) $display("FAIL credit_stable: got %b want 1", stable); else pass_cnt++;
      pop_en = 1'b1;
      for (int i = 0; i < 400 && seen < 20; i++) begin
         tick();
         if (ev_accept) begin
            chk_cnt++;
            if (exp_addr_q.size() == 0) $display("FAIL credit_addr: extra request %0h", ev_addr);
            else begin ea = exp_addr_q.pop_front(); if (ev_addr !== ea) $display("FAIL credit_addr: got %0h want %0h", ev_addr, ea); else pass_cnt++; end
         end
         if (acc_user_read_data_valid) begin
            chk_cnt++;
            if (exp_data_q.size() == 0) $display("FAIL credit_data: unexpected line %0h", acc_user_read_data);
            else begin ed = exp_data_q.pop_front(); if (acc_user_read_data !== ed) $display("FAIL credit_data: got %0h want %0h", acc_user_read_data, ed); else pass_cnt++; end
            seen++;
         end
      end
      chk_cnt++; if (seen !== 20) $display("FAIL credit_count: got %0d lines want 20", seen); else pass_cnt++;
      tick();
      chk_cnt++; if (acc_user_done_rd_data !== 1'b1) $display("FAIL credit_done: got %b want 1", acc_user_done_rd_data); else pass_cnt++;
   endtask

   task automatic test_ready_stall();
      int seen = 0;
      logic v_ok;
      logic a_ok = 1'b1;
      logic [63:0]  hold;
      logic [63:0]  ea;
      logic [511:0] ed;
      pop_en = 1'b1;
      mem_req_ready = 1'b1;
      do_start(64'h8000, 12);
      for (int i = 0; i < 100 && seen < 12; i++) begin
         if (i == 4) begin
            mem_req_ready = 1'b0;
            hold = mem_req_addr;
            v_ok = mem_req_valid;
         end
         if (i == 9) mem_req_ready = 1'b1;
         tick();
         if (i >= 4 && i < 9) begin
            if (mem_req_valid !== 1'b1) v_ok = 1'b0;
            if (mem_req_addr !== hold) a_ok = 1'b0;
         end
         if (ev_accept) begin
            chk_cnt++;
            if (exp_addr_q.size() == 0) $display("FAIL stall_addr: extra request %0h", ev_addr);
            else begin ea = exp_addr_q.pop_front(); if (ev_addr !== ea) $display("FAIL stall_addr: got %0h want %0h", ev_addr, ea); else pass_cnt++; end
         end
         if (acc_user_read_data_valid) begin
            chk_cnt++;
            if (exp_data_q.size() == 0) $display("FAIL stall_data: unexpected line %0h", acc_user_read_data);
            else begin ed = exp_data_q.pop_front(); if (acc_user_read_data !== ed) $display("FAIL stall_data: got %0h want %0h", acc_user_read_data, ed); else pass_cnt++; end
            seen++;
         end
      end
      chk_cnt++; if (v_ok !== 1'b1) $display("FAIL stall_valid_held: got %b want 1", v_ok); else pass_cnt++;
      chk_cnt++; if (a_ok !== 1'b1) $display("FAIL stall_addr_held: got %b want 1", a_ok); else pass_cnt++;
      chk_cnt++; if (seen !== 12) $display("FAIL stall_count: got %0d lines want 12", seen); else pass_cnt++;
      chk_cnt++; if (exp_addr_q.size() !== 0) $display("FAIL stall_addr_left: got %0d want 0", exp_addr_q.size()); else pass_cnt++;
      tick();
      chk_cnt++; if (acc_user_done_rd_data !== 1'b1) $display("FAIL stall_done: got %b want 1", acc_user_done_rd_data); else pass_cnt++;
   endtask

   task automatic test_corner_pops();
      int seen = 0;
      logic bad = 1'b0;
      logic [63:0]  ea;
      logic [511:0] ed;
      pop_en = 1'b0;
      pop_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (acc_user_read_data_valid || acc_user_available_read) bad = 1'b1;
      end
      pop_force = 1'b0;
      tick();
      if (acc_user_read_data_valid || acc_user_available_read) bad = 1'b1;
      chk_cnt++; if (bad !== 1'b0) $display("FAIL corner_empty_pop: got %b want 0", bad); else pass_cnt++;
      do_start(64'hC000, 3);
      for (int i = 0; i < 20 && !acc_user_available_read; i++) begin
         tick();
         if (ev_accept) begin
            chk_cnt++;
            ea = exp_addr_q.pop_front();
            if (ev_addr !== ea) $display("FAIL corner_addr: got %0h want %0h", ev_addr, ea); else pass_cnt++;
         end
      end
      chk_cnt++; if (acc_user_available_read !== 1'b1) $display("FAIL corner_first_avail: got %b want 1", acc_user_available_read); else pass_cnt++;
      acc_user_request_read = 1'b1;
      tick();
      chk_cnt++; if (acc_user_read_data_valid !== 1'b1) $display("FAIL corner_pushpop_valid: got %b want 1", acc_user_read_data_valid); else pass_cnt++;
      ed = exp_data_q.pop_front();
      chk_cnt++; if (acc_user_read_data !== ed) $display("FAIL corner_pushpop_data: got %0h want %0h", acc_user_read_data, ed); else pass_cnt++;
      chk_cnt++; if (acc_user_available_read !== 1'b1) $display("FAIL corner_pushpop_avail: got %b want 1", acc_user_available_read); else pass_cnt++;
      seen = 1;
      pop_en = 1'b1;
      for (int i = 0; i < 40 && seen < 3; i++) begin
         tick();
         if (acc_user_read_data_valid) begin
            chk_cnt++;
            if (exp_data_q.size() == 0) $display("FAIL corner_data: unexpected line %0h", acc_user_read_data);
            else begin ed = exp_data_q.pop_front(); if (acc_user_read_data !== ed) $display("FAIL corner_data: got %0h want %0h", acc_user_read_data, ed); else pass_cnt++; end
            seen++;
         end
      end
      chk_cnt++; if (seen !== 3) $display("FAIL corner_count: got %0d lines want 3", seen); else pass_cnt++;
      tick();
      chk_cnt++; if (acc_user_done_rd_data !== 1'b1) $display("FAIL corner_done: got %b want 1", acc_user_done_rd_data); else pass_cnt++;
      exp_addr_q.delete();
   endtask

   task automatic test_reset_rearm();
      int seen = 0;
      logic zero_ok = 1'b1;
      logic [511:0] ed;
      pop_en = 1'b1;
      do_start(64'h10000, 10);
      for (int i = 0; i < 60 && seen < 3; i++) begin
         tick();
         if (acc_user_read_data_valid) begin
            chk_cnt++;
            ed = exp_data_q.pop_front();
            if (acc_user_read_data !== ed) $display("FAIL rearm_pre_data: got %0h want %0h", acc_user_read_data, ed); else pass_cnt++;
            seen++;
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      pend_addr.delete();
      pend_due.delete();
      pend_addr.push_back(64'hDEAD_0000);
      pend_due.push_back(0);
      pend_addr.push_back(64'hDEAD_0040);
      pend_due.push_back(0);
      for (int i = 0; i < 5; i++) begin
         if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0 || acc_user_available_read !== 1'b0 ||
             acc_user_read_data_valid !== 1'b0 || acc_user_read_data !== 512'h0 || acc_user_done_rd_data !== 1'b0)
            zero_ok = 1'b0;
         tick();
      end
      chk_cnt++; if (zero_ok !== 1'b1) $display("FAIL rearm_outputs_zero: got %b want 1", zero_ok); else pass_cnt++;
      chk_cnt++; if (acc_user_available_read !== 1'b0) $display("FAIL rearm_stale_dropped: got %b want 0", acc_user_available_read); else pass_cnt++;
      seen = 0;
      do_start(64'h0, 2);
      for (int i = 0; i < 40 && seen < 2; i++) begin
         tick();
         if (acc_user_read_data_valid) begin
            chk_cnt++;
            if (exp_data_q.size() == 0) $display("FAIL rearm_data: unexpected line %0h", acc_user_read_data);
            else begin ed = exp_data_q.pop_front(); if (acc_user_read_data !== ed) $display("FAIL rearm_data: got %0h want %0h", acc_user_read_data, ed); else pass_cnt++; end
            seen++;
         end
      end
      chk_cnt++; if (seen !== 2) $display("FAIL rearm_count: got %0d lines want 2", seen); else pass_cnt++;
      tick();
      chk_cnt++; if (acc_user_done_rd_data !== 1'b1) $display("FAIL rearm_done: got %b want 1", acc_user_done_rd_data); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (acc_user_read_data_valid) seen++;
      end
      chk_cnt++; if (seen !== 2) $display("FAIL rearm_no_extra: got %0d lines want 2", seen); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      num_lines = '0;
      mem_req_ready = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data = '0;
      acc_user_request_read = 1'b0;
      test_reset();
      test_basic();
      test_zero_length();
      test_credit();
      test_ready_stall();
      test_corner_pops();
      test_reset_rearm();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", chk_cnt);
      $fatal(1);
   end

endmodule
